// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU request into one or two NB-aligned memory beats.
// Boundary-crossing accesses are split or rejected, and load data is extended to XLEN.
module load_store_unit #(
   parameter int XLEN             = 32,
   parameter int ADDR_W           = 32,
   parameter int ALLOW_MISALIGNED = 1,
   parameter int TIMEOUT          = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [2:0]          req_funct3_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [XLEN-1:0]     req_wdata_i,
   output logic                resp_valid_o,
   output logic [XLEN-1:0]     resp_rdata_o,
   output logic                resp_err_o,
   output logic                mem_read_o,
   output logic [XLEN/8-1:0]   mem_wstrb_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [XLEN-1:0]     mem_wdata_o,
   input  logic [XLEN-1:0]     mem_rdata_i,
   input  logic                mem_ack_i
);

   localparam int NB    = XLEN / 8;
   localparam int NB2   = 2 * NB;
   localparam int XL2   = 2 * XLEN;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   function automatic logic is_legal(input logic we, input logic [2:0] f3);
      logic ok;
      if (we)
         ok = (f3 inside {3'b000, 3'b001, 3'b010}) || (XLEN == 64 && f3 == 3'b011);
      else
         ok = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
              (XLEN == 64 && (f3 == 3'b011 || f3 == 3'b110));
      return ok;
   endfunction

   function automatic logic is_crossing(input logic [OFF_W-1:0] off, input logic [1:0] sz);
      return (int'(off) + (1 << sz)) > NB;
   endfunction

   // hi selects the strobes that spill into the second beat
   function automatic logic [NB-1:0] strobe_beat(input logic [OFF_W-1:0] off,
                                                 input logic [1:0] sz, input logic hi);
      logic [NB2-1:0] m;
      m = NB2'((1 << (1 << sz)) - 1) << off;
      return hi ? m[NB2-1:NB] : m[NB-1:0];
   endfunction

   function automatic logic [XLEN-1:0] lane_beat(input logic [OFF_W-1:0] off,
                                                 input logic [XLEN-1:0] wdata, input logic hi);
      logic [XL2-1:0] w;
      w = XL2'({{XLEN{1'b0}}, wdata} << {off, 3'b000});
      return hi ? w[XL2-1:XLEN] : w[XLEN-1:0];
   endfunction

   function automatic logic [XLEN-1:0] load_extend(input logic [XL2-1:0] beats,
                                                   input logic [OFF_W-1:0] off,
                                                   input logic [2:0] f3);
      logic [XLEN-1:0]    low;
      logic [XLEN-1:0]    res;
      logic signed [7:0]  s8;
      logic signed [15:0] s16;
      logic signed [31:0] s32;
      low = XLEN'(beats >> {off, 3'b000});
      s8  = low[7:0];
      s16 = low[15:0];
      s32 = low[31:0];
      case (f3[1:0])
         2'd0: if (f3[2]) res = XLEN'(low[7:0]);  else res = XLEN'(s8);
         2'd1: if (f3[2]) res = XLEN'(low[15:0]); else res = XLEN'(s16);
         2'd2: if (f3[2]) res = XLEN'(low[31:0]); else res = XLEN'(s32);
         default: res = low;
      endcase
      return res;
   endfunction

   state_t            state_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   beat0_q;
   logic [31:0]       cnt_q;

   logic [OFF_W-1:0]  req_off, lat_off;
   logic              req_ok, lat_cross, timed_out;
   logic [NB-1:0]     req_strb_d, hi_strb_d;
   logic [XLEN-1:0]   req_lane_d, hi_lane_d;
   logic [ADDR_W-1:0] req_base_d, hi_addr_d;

   assign req_off    = req_addr_i[OFF_W-1:0];
   assign lat_off    = addr_q[OFF_W-1:0];
   assign req_ok     = is_legal(req_we_i, req_funct3_i) &&
                       (ALLOW_MISALIGNED != 0 || !is_crossing(req_off, req_funct3_i[1:0]));
   assign lat_cross  = is_crossing(lat_off, f3_q[1:0]);
   assign timed_out  = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
   assign req_strb_d = strobe_beat(req_off, req_funct3_i[1:0], 1'b0);
   assign hi_strb_d  = strobe_beat(lat_off, f3_q[1:0], 1'b1);
   assign req_lane_d = lane_beat(req_off, req_wdata_i, 1'b0);
   assign hi_lane_d  = lane_beat(lat_off, wdata_q, 1'b1);
   assign req_base_d = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   // second beat address wraps naturally at 2^ADDR_W
   assign hi_addr_d  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + ADDR_W'(NB);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         mem_read_o   <= 1'b0;
         mem_wstrb_o  <= '0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         we_q         <= 1'b0;
         f3_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         beat0_q      <= '0;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q        <= req_we_i;
                  f3_q        <= req_funct3_i;
                  addr_q      <= req_addr_i;
                  wdata_q     <= req_wdata_i;
                  cnt_q       <= '0;
                  req_ready_o <= 1'b0;
                  if (!req_ok) begin
                     state_q      <= RESP;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_rdata_o <= '0;
                  end else begin
                     state_q     <= ACC0;
                     mem_addr_o  <= req_base_d;
                     mem_read_o  <= !req_we_i;
                     mem_wstrb_o <= req_we_i ? req_strb_d : '0;
                     mem_wdata_o <= req_we_i ? req_lane_d : '0;
                  end
               end
            end
            ACC0, ACC1: begin
               if (mem_ack_i) begin
                  cnt_q <= '0;
                  if (state_q == ACC0 && lat_cross) begin
                     state_q     <= ACC1;
                     beat0_q     <= mem_rdata_i;
                     mem_addr_o  <= hi_addr_d;
                     mem_wstrb_o <= we_q ? hi_strb_d : '0;
                     mem_wdata_o <= we_q ? hi_lane_d : '0;
                  end else begin
                     state_q      <= RESP;
                     mem_read_o   <= 1'b0;
                     mem_wstrb_o  <= '0;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b0;
                     if (we_q)
                        resp_rdata_o <= '0;
                     else if (state_q == ACC1)
                        resp_rdata_o <= load_extend({mem_rdata_i, beat0_q}, lat_off, f3_q);
                     else
                        resp_rdata_o <= load_extend({{XLEN{1'b0}}, mem_rdata_i}, lat_off, f3_q);
                  end
               end else if (timed_out) begin
                  state_q      <= RESP;
                  mem_read_o   <= 1'b0;
                  mem_wstrb_o  <= '0;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b1;
                  resp_rdata_o <= '0;
                  cnt_q        <= '0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            RESP: begin
               state_q      <= IDLE;
               req_ready_o  <= 1'b1;
               resp_valid_o <= 1'b0;
               resp_err_o   <= 1'b0;
               resp_rdata_o <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a memory responder checks each beat against
// queued expectations and a monitor checks every response pulse against queued results.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_read;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   // strict instance: misaligned accesses rejected, memory never answers
   logic        s_req_valid = 1'b0, s_req_ready, s_req_we = 1'b0;
   logic [2:0]  s_req_funct3 = '0;
   logic [31:0] s_req_addr = '0, s_req_wdata = '0;
   logic        s_resp_valid, s_resp_err, s_mem_read;
   logic [31:0] s_resp_rdata, s_mem_addr, s_mem_wdata;
   logic [3:0]  s_mem_wstrb;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1), .TIMEOUT(8)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
      .resp_err_o(resp_err), .mem_read_o(mem_read), .mem_wstrb_o(mem_wstrb),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .mem_ack_i(mem_ack));

   load_store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0), .TIMEOUT(16)) u_strict (
      .clk_i(clk), .rst_i(rst), .req_valid_i(s_req_valid), .req_ready_o(s_req_ready),
      .req_we_i(s_req_we), .req_funct3_i(s_req_funct3), .req_addr_i(s_req_addr),
      .req_wdata_i(s_req_wdata), .resp_valid_o(s_resp_valid), .resp_rdata_o(s_resp_rdata),
      .resp_err_o(s_resp_err), .mem_read_o(s_mem_read), .mem_wstrb_o(s_mem_wstrb),
      .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata), .mem_rdata_i(32'h0),
      .mem_ack_i(1'b0));

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      total++;
      $display("FAIL %s: event did not occur as expected", nm);
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
      string       name;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic [3:0]  strb;
      logic [31:0] wdata;
      string       name;
   } beat_t;

   resp_t exp_q[$];
   beat_t beat_q[$];

   logic [31:0] mem [logic [31:0]];
   int  wait_cnt   = 0;
   int  ack_delay  = 0;
   int  acks_left  = 1000;
   bit  ack_en     = 1'b1;
   int  rd_cycles  = 0;
   bit  s_read_seen = 1'b0;

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_read) rd_cycles <= rd_cycles + 1;
      if (s_mem_read) s_read_seen <= 1'b1;
      if (!(mem_read || mem_wstrb != 0) || mem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   // memory responder: acks at negedge, checks the beat it is completing
   always @(negedge clk) begin
      beat_t b;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (!rst && (mem_read || mem_wstrb != 0) && ack_en && acks_left > 0 &&
          wait_cnt >= ack_delay) begin
         mem_ack   = 1'b1;
         mem_rdata = rd_word(mem_addr);
         acks_left--;
         if (beat_q.size() == 0) begin
            fail("unexpected_beat");
         end else begin
            b = beat_q.pop_front();
            chk({b.name, "_addr"}, mem_addr, b.addr);
            chk({b.name, "_read"}, {31'b0, mem_read}, {31'b0, b.rd});
            chk({b.name, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, b.strb});
            if (!b.rd) chk({b.name, "_wdata"}, mem_wdata, b.wdata);
         end
         if (mem_wstrb != 0) begin
            logic [31:0] w;
            w = rd_word(mem_addr);
            for (int i = 0; i < 4; i++)
               if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            mem[mem_addr] = w;
         end
      end
   end

   // response monitor
   always @(negedge clk) begin
      resp_t e;
      if (!rst && resp_valid) begin
         if (exp_q.size() == 0) begin
            fail("unexpected_resp");
         end else begin
            e = exp_q.pop_front();
            chk({e.name, "_rdata"}, resp_rdata, e.rdata);
            chk({e.name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
            chk({e.name, "_latency"}, 32'(cyc + 1 - e.acc), 32'(e.lat));
         end
      end
   end

   task automatic push_beat(input string nm, input logic [31:0] a, input logic r,
                            input logic [3:0] s, input logic [31:0] wd);
      beat_t b;
      b.addr = a; b.rd = r; b.strb = s; b.wdata = wd; b.name = nm;
      beat_q.push_back(b);
   endtask

   task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input bit want_resp);
      resp_t e;
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) fail({nm, "_ready"});
      @(posedge clk);
      #1;
      e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.acc = cyc; e.name = nm;
      if (want_resp) exp_q.push_back(e);
      // scramble inputs so any use of unlatched request fields shows up
      req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
      req_addr = 32'h0BAD_0BAD; req_wdata = 32'h5A5A_A5A5;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || beat_q.size() != 0) && n < 60) begin
         @(negedge clk); n++;
      end
      if (n >= 60) begin
         fail({nm, "_completion"});
         exp_q.delete();
         beat_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      mem[32'h1000] = 32'h80FF_1234;
      mem[32'h3000] = 32'h4433_2211;
      mem[32'h3004] = 32'h8877_6655;

      repeat (3) @(negedge clk);
      chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_mem_read",   {31'b0, mem_read},   32'd0);
      chk("rst_mem_wstrb",  {28'b0, mem_wstrb},  32'd0);
      chk("rst_mem_addr",   mem_addr,            32'd0);
      rst = 1'b0;

      push_beat("lb", 32'h1000, 1'b1, 4'b0000, 32'h0);
      issue("lb", 1'b0, 3'b000, 32'h1003, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b1);
      wait_done("lb");

      push_beat("lbu", 32'h1000, 1'b1, 4'b0000, 32'h0);
      issue("lbu", 1'b0, 3'b100, 32'h1003, 32'h0, 32'h0000_0080, 1'b0, 2, 1'b1);
      wait_done("lbu");

      push_beat("sh", 32'h2000, 1'b0, 4'b1100, 32'hABCD_0000);
      issue("sh", 1'b1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 1'b0, 2, 1'b1);
      wait_done("sh");

      push_beat("lw_x0", 32'h3000, 1'b1, 4'b0000, 32'h0);
      push_beat("lw_x1", 32'h3004, 1'b1, 4'b0000, 32'h0);
      issue("lw_x", 1'b0, 3'b010, 32'h3003, 32'h0, 32'h7766_5544, 1'b0, 3, 1'b1);
      wait_done("lw_x");

      ack_delay = 2;
      push_beat("lh_wait", 32'h1000, 1'b1, 4'b0000, 32'h0);
      issue("lh_wait", 1'b0, 3'b001, 32'h1002, 32'h0, 32'hFFFF_80FF, 1'b0, 4, 1'b1);
      wait_done("lh_wait");
      ack_delay = 0;

      push_beat("lhu", 32'h1000, 1'b1, 4'b0000, 32'h0);
      issue("lhu", 1'b0, 3'b101, 32'h1001, 32'h0, 32'h0000_FF12, 1'b0, 2, 1'b1);
      wait_done("lhu");

      issue("ld_illegal", 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      wait_done("ld_illegal");
      issue("st_illegal", 1'b1, 3'b100, 32'h1000, 32'h1234, 32'h0, 1'b1, 1, 1'b1);
      wait_done("st_illegal");

      push_beat("sw_wrap0", 32'hFFFF_FFFC, 1'b0, 4'b1100, 32'hC3D4_0000);
      push_beat("sw_wrap1", 32'h0000_0000, 1'b0, 4'b0011, 32'h0000_A1B2);
      issue("sw_wrap", 1'b1, 3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'h0, 1'b0, 3, 1'b1);
      wait_done("sw_wrap");

      push_beat("lw_wrap0", 32'hFFFF_FFFC, 1'b1, 4'b0000, 32'h0);
      push_beat("lw_wrap1", 32'h0000_0000, 1'b1, 4'b0000, 32'h0);
      issue("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'hA1B2_C3D4, 1'b0, 3, 1'b1);
      wait_done("lw_wrap");

      ack_en = 1'b0;
      rd_cycles = 0;
      issue("timeout", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 9, 1'b1);
      wait_done("timeout");
      chk("timeout_read_cycles", 32'(rd_cycles), 32'd8);
      ack_en = 1'b1;

      begin
         int n = 0;
         acks_left = 1;
         push_beat("rst_acc0", 32'h3000, 1'b1, 4'b0000, 32'h0);
         issue("rst_mid", 1'b0, 3'b010, 32'h3003, 32'h0, 32'h0, 1'b0, 0, 1'b0);
         while (!(mem_read && mem_addr == 32'h3004) && n < 20) begin @(negedge clk); n++; end
         if (n >= 20) fail("rst_mid_reach_acc1");
         #2 rst = 1'b1;
         #1;
         chk("rst_mid_mem_read",   {31'b0, mem_read},   32'd0);
         chk("rst_mid_mem_wstrb",  {28'b0, mem_wstrb},  32'd0);
         chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
         chk("rst_mid_req_ready",  {31'b0, req_ready},  32'd1);
         @(negedge clk);
         rst = 1'b0;
         acks_left = 1000;
         beat_q.delete();
      end
      push_beat("after_rst", 32'h1000, 1'b1, 4'b0000, 32'h0);
      issue("after_rst", 1'b0, 3'b000, 32'h1003, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b1);
      wait_done("after_rst");

      // strict instance: crossing LW is rejected one cycle after acceptance
      s_read_seen = 1'b0;
      @(negedge clk);
      chk("strict_ready", {31'b0, s_req_ready}, 32'd1);
      s_req_valid = 1'b1; s_req_we = 1'b0; s_req_funct3 = 3'b010; s_req_addr = 32'h3003;
      @(posedge clk);
      #1 s_req_valid = 1'b0;
      @(negedge clk);
      chk("strict_resp_valid", {31'b0, s_resp_valid}, 32'd1);
      chk("strict_resp_err",   {31'b0, s_resp_err},   32'd1);
      @(negedge clk);
      chk("strict_resp_pulse", {31'b0, s_resp_valid}, 32'd0);
      chk("strict_no_read",    {31'b0, s_read_seen},  32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, data width in bits; legal values 32 and 64; NB = XLEN/8 bytes per beat.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter ALLOW_MISALIGNED, default 1; 1 = split boundary-crossing accesses into two beats, 0 = reject them with an error.
REQ-004 Parameter TIMEOUT, default 16; maximum cycles to wait for mem_ack per beat; 0 disables the timeout.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high: clk  in  1  clock, all state on rising edge; rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  CPU request present; req_ready  out  1  unit idle, request accepted when both high.
REQ-007 req_we  in  1  1 = store, 0 = load; req_funct3  in  3  RISC-V size/sign code; req_addr  in  ADDR_W  byte address; req_wdata  in  XLEN  store data, LSB-aligned.
REQ-008 resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  XLEN  extended load data; resp_err  out  1  misaligned, illegal or timed out.
REQ-009 mem_read  out  1  read beat; mem_wstrb  out  NB  byte write strobes; mem_addr  out  ADDR_W  NB-aligned beat address; mem_wdata  out  XLEN  lane-positioned write data.
REQ-010 mem_rdata  in  XLEN  read data, valid with ack; mem_ack  in  1  current beat complete.

Function
REQ-011 States SHALL be IDLE, ACC0, ACC1, RESP; req_ready = 1 only in IDLE.
REQ-012 On acceptance, the unit SHALL latch req_we, req_funct3, req_addr and req_wdata; later req_* changes SHALL have no effect.
REQ-013 size = 1 << funct3[1:0] bytes; off = addr mod NB; crossing = off + size > NB.
REQ-014 Legal loads: funct3 000,001,010,100,101; also 011 and 110 when XLEN=64. Legal stores: 000,001,010; also 011 when XLEN=64.
REQ-015 An illegal funct3, or crossing with ALLOW_MISALIGNED=0, SHALL take IDLE->RESP with resp_err=1 and perform no memory beat.
REQ-016 Otherwise IDLE->ACC0 drives mem_addr = addr with the low log2(NB) bits cleared; mem_read = !we; mem_wstrb = low NB bits of (((1<<size)-1) << off) when we.
REQ-017 Store mem_wdata SHALL be the low XLEN bits of (wdata << 8*off) in ACC0; in ACC1 it SHALL be wdata >> 8*(NB-off).
REQ-018 Beat signals SHALL be held constant until mem_ack is sampled high; on ack, mem_rdata SHALL be captured.
REQ-019 After the ACC0 ack, crossing SHALL go to ACC1, otherwise to RESP.
REQ-020 ACC1 mem_addr = ACC0 address + NB, wrapping modulo 2^ADDR_W; store strobes = remaining high bits of the shifted mask, shifted down by NB.
REQ-021 Load result = ({beat1, beat0} >> 8*off) truncated to size bytes; sign-extended to XLEN when funct3[2]=0, zero-extended when 1.
REQ-022 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; stores return resp_rdata = 0.
REQ-023 Latency, aligned access with same-cycle ack: accept at T, beat at T+1, resp_valid at T+2; each wait cycle or extra beat adds 1.
REQ-024 The wait counter SHALL reset at each beat start; reaching TIMEOUT cycles without ack SHALL abort remaining beats and go to RESP with resp_err=1 and resp_rdata=0.
REQ-025 mem_ack outside ACC0/ACC1 SHALL be ignored; mem_read and mem_wstrb SHALL be 0 outside ACC0/ACC1.

Reset
REQ-026 rst high SHALL immediately force IDLE and zero the counter, latches, and all outputs except req_ready (=1), including mid-beat.
REQ-027 After rst is released, the first clk edge with req_valid=1 SHALL accept a request.

Verification
REQ-028 LB at 0x1003, word at 0x1000 = 0x80FF_1234 -> resp_rdata 0xFFFF_FF80; LBU -> 0x0000_0080; resp_err 0.
REQ-029 SH at 0x2002, wdata 0x0000_ABCD -> mem_addr 0x2000, mem_wstrb 4'b1100, mem_wdata 0xABCD_0000, single beat.
REQ-030 LW at 0x3003, ALLOW_MISALIGNED=1, 0x3000 = 0x4433_2211, 0x3004 = 0x8877_6655 -> beats 0x3000 then 0x3004, resp_rdata 0x7766_5544.
REQ-031 Same LW with ALLOW_MISALIGNED=0 -> resp_valid and resp_err at T+1, mem_read never high.
REQ-032 TIMEOUT=8, mem_ack held 0 -> mem_read high 8 cycles, then resp_err=1; SW at 0xFFFF_FFFE crossing wraps second beat to 0x0000_0000.
REQ-033 rst pulsed during ACC1 -> mem_read, mem_wstrb, resp_valid 0 at once; req_ready 1; next request completes normally.
